// File: rtl/mem_arbiter_if.sv
// Bundle of the two requester ports and the single-port memory command/return path.
// slave = arbiter view, master = environment (requesters + memory) view.
interface mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic              a_req;
    logic              a_we;
    logic              a_lock;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_gnt;
    logic [DATA_W-1:0] a_rdata;
    logic              a_rvalid;

    logic              b_req;
    logic              b_we;
    logic              b_lock;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic              b_gnt;
    logic [DATA_W-1:0] b_rdata;
    logic              b_rvalid;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  a_req, a_we, a_lock, a_addr, a_wdata,
        output a_gnt, a_rdata, a_rvalid,
        input  b_req, b_we, b_lock, b_addr, b_wdata,
        output b_gnt, b_rdata, b_rvalid,
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output a_req, a_we, a_lock, a_addr, a_wdata,
        input  a_gnt, a_rdata, a_rvalid,
        output b_req, b_we, b_lock, b_addr, b_wdata,
        input  b_gnt, b_rdata, b_rvalid,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter with bounded lock in front of a single-port byte memory.
// Optional macro MEM_ARB_TRACE_EN: grant/rvalid trace plus a double-grant simulation check.
module mem_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 8,
    parameter int MAX_LOCK = 8
) (
    input logic          clk,
    input logic          reset,
    mem_arbiter_if.slave bus
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOCK_A = 2'd1;
    localparam logic [1:0] ST_LOCK_B = 2'd2;
    localparam logic       PORT_A    = 1'b0;
    localparam logic       PORT_B    = 1'b1;
    localparam logic [7:0] MAX_CNT   = MAX_LOCK[7:0];

    logic [1:0]        state_q, state_d;
    logic [7:0]        lock_cnt_q, lock_cnt_d;
    logic              last_gnt_q, last_gnt_d;
    logic              mem_read_q, mem_write_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              tag1_valid_q, tag1_port_q;
    logic              tag2_valid_q, tag2_port_q;

    logic              gnt_a, gnt_b, any_gnt;
    logic              hold_a, hold_b, cap;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;

    assign hold_a = (state_q == ST_LOCK_A) && bus.a_req && bus.a_lock;
    assign hold_b = (state_q == ST_LOCK_B) && bus.b_req && bus.b_lock;
    assign cap    = (lock_cnt_q == MAX_CNT);

    // A held lock only yields once its count has reached the bound and the other side waits.
    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (hold_a) begin
            if (cap && bus.b_req) gnt_b = 1'b1;
            else                  gnt_a = 1'b1;
        end else if (hold_b) begin
            if (cap && bus.a_req) gnt_a = 1'b1;
            else                  gnt_b = 1'b1;
        end else if (bus.a_req && bus.b_req) begin
            if (last_gnt_q == PORT_B) gnt_a = 1'b1;
            else                      gnt_b = 1'b1;
        end else begin
            gnt_a = bus.a_req;
            gnt_b = bus.b_req;
        end
    end

    assign any_gnt   = gnt_a || gnt_b;
    assign win_we    = gnt_a ? bus.a_we    : bus.b_we;
    assign win_addr  = gnt_a ? bus.a_addr  : bus.b_addr;
    assign win_wdata = gnt_a ? bus.a_wdata : bus.b_wdata;

    always_comb begin
        state_d    = ST_IDLE;
        lock_cnt_d = 8'd0;
        last_gnt_d = last_gnt_q;
        if (gnt_a) begin
            last_gnt_d = PORT_A;
            if (bus.a_lock) begin
                state_d    = ST_LOCK_A;
                lock_cnt_d = hold_a ? (cap ? lock_cnt_q : lock_cnt_q + 8'd1) : 8'd1;
            end
        end else if (gnt_b) begin
            last_gnt_d = PORT_B;
            if (bus.b_lock) begin
                state_d    = ST_LOCK_B;
                lock_cnt_d = hold_b ? (cap ? lock_cnt_q : lock_cnt_q + 8'd1) : 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            lock_cnt_q   <= 8'd0;
            last_gnt_q   <= PORT_B;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            tag1_valid_q <= 1'b0;
            tag1_port_q  <= PORT_A;
            tag2_valid_q <= 1'b0;
            tag2_port_q  <= PORT_A;
        end else begin
            state_q     <= state_d;
            lock_cnt_q  <= lock_cnt_d;
            last_gnt_q  <= last_gnt_d;
            mem_read_q  <= any_gnt && !win_we;
            mem_write_q <= any_gnt && win_we;
            if (any_gnt) begin
                mem_addr_q  <= win_addr;
                mem_wdata_q <= win_wdata;
            end
            // Tag follows the read through the memory's one-cycle command and one-cycle data latency.
            tag1_valid_q <= any_gnt && !win_we;
            tag1_port_q  <= gnt_b;
            tag2_valid_q <= tag1_valid_q;
            tag2_port_q  <= tag1_port_q;
        end
    end

    assign bus.a_gnt     = gnt_a;
    assign bus.b_gnt     = gnt_b;
    assign bus.mem_read  = mem_read_q;
    assign bus.mem_write = mem_write_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.a_rdata   = bus.mem_rdata;
    assign bus.b_rdata   = bus.mem_rdata;
    assign bus.a_rvalid  = tag2_valid_q && (tag2_port_q == PORT_A);
    assign bus.b_rvalid  = tag2_valid_q && (tag2_port_q == PORT_B);

`ifdef MEM_ARB_TRACE_EN
    always @(posedge clk) begin
        if (!reset) begin
            if (gnt_a && gnt_b) begin
                $display("mem_arbiter: double grant");
                $finish;
            end
            if (any_gnt) begin
                if (win_we)
                    $display("%0t mem_arbiter grant %s W addr=%h wdata=%h", $time,
                             gnt_a ? "A" : "B", win_addr, win_wdata);
                else
                    $display("%0t mem_arbiter grant %s R addr=%h", $time,
                             gnt_a ? "A" : "B", win_addr);
            end
            if (bus.a_rvalid) $display("%0t mem_arbiter rvalid A data=%h", $time, bus.a_rdata);
            if (bus.b_rvalid) $display("%0t mem_arbiter rvalid B data=%h", $time, bus.b_rdata);
        end
    end
`else
    // Trace and double-grant check are compiled out; datapath is unchanged.
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: 256-byte aliased memory model, shadow copy and read scoreboard.
module tb_mem_arbiter;
    logic clk;
    logic reset;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   ga_cnt = 0;
    int   gb_cnt = 0;

    typedef struct {
        logic       port;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] mem    [0:255];
    logic [7:0] shadow [0:255];

    mem_arbiter_if #(.ADDR_W(16), .DATA_W(8)) bus ();

    mem_arbiter #(.ADDR_W(16), .DATA_W(8), .MAX_LOCK(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] pat(input logic [7:0] a);
        logic [7:0] v;
        v = a * 8'h1D + 8'h07;
        return (a == 8'h10) ? 8'h5A : v;
    endfunction

    // Memory: samples command on the edge after it is registered, returns data one cycle later.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= pat(8'(i));
        end else begin
            if (bus.mem_write) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
            if (bus.mem_read)  bus.mem_rdata <= mem[bus.mem_addr[7:0]];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (bus.a_rvalid || bus.b_rvalid) begin
            if (sb.size() == 0) begin
                check("rv_unexpected", 32'({bus.a_rvalid, bus.b_rvalid}), 32'b00);
            end else begin
                e = sb.pop_front();
                $display("[TB] cyc %0d rvalid A=%0b B=%0b data=%h", cyc, bus.a_rvalid, bus.b_rvalid,
                         e.port ? bus.b_rdata : bus.a_rdata);
                check("rv_port", 32'({bus.a_rvalid, bus.b_rvalid}), e.port ? 32'b01 : 32'b10);
                check("rv_data", 32'(e.port ? bus.b_rdata : bus.a_rdata), 32'(e.data));
                check("rv_cycle", 32'(cyc), 32'(e.cyc));
            end
        end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            check("rv_missing", 32'({bus.a_rvalid, bus.b_rvalid}), e.port ? 32'b01 : 32'b10);
        end
    end

    task automatic drive_a(input logic req, input logic we, input logic lock,
                           input logic [15:0] addr, input logic [7:0] wdata);
        bus.a_req = req; bus.a_we = we; bus.a_lock = lock; bus.a_addr = addr; bus.a_wdata = wdata;
    endtask

    task automatic drive_b(input logic req, input logic we, input logic lock,
                           input logic [15:0] addr, input logic [7:0] wdata);
        bus.b_req = req; bus.b_we = we; bus.b_lock = lock; bus.b_addr = addr; bus.b_wdata = wdata;
    endtask

    task automatic idle();
        drive_a(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
        drive_b(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
    endtask

    // One arbitration cycle: check grants, update the shadow/scoreboard from the expected winner.
    task automatic cycle(input logic ea, input logic eb, input string tag);
        exp_t e;
        #1;
        $display("[TB] cyc %0d %s a_gnt=%0b b_gnt=%0b", cyc, tag, bus.a_gnt, bus.b_gnt);
        check($sformatf("%s.a_gnt", tag), 32'(bus.a_gnt), 32'(ea));
        check($sformatf("%s.b_gnt", tag), 32'(bus.b_gnt), 32'(eb));
        ga_cnt += int'(bus.a_gnt);
        gb_cnt += int'(bus.b_gnt);
        if (ea) begin
            if (bus.a_we) shadow[bus.a_addr[7:0]] = bus.a_wdata;
            else begin
                e.port = 1'b0; e.data = shadow[bus.a_addr[7:0]]; e.cyc = cyc + 2;
                sb.push_back(e);
            end
        end
        if (eb) begin
            if (bus.b_we) shadow[bus.b_addr[7:0]] = bus.b_wdata;
            else begin
                e.port = 1'b1; e.data = shadow[bus.b_addr[7:0]]; e.cyc = cyc + 2;
                sb.push_back(e);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        sb.delete();
        for (int i = 0; i < 256; i++) shadow[i] = pat(8'(i));
        repeat (2) begin
            @(posedge clk); #1;
        end
        reset = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        #1;
        check({tag, ".mem_read"},  32'(bus.mem_read),  32'd0);
        check({tag, ".mem_write"}, 32'(bus.mem_write), 32'd0);
        check({tag, ".mem_addr"},  32'(bus.mem_addr),  32'd0);
        check({tag, ".mem_wdata"}, 32'(bus.mem_wdata), 32'd0);
        check({tag, ".a_rvalid"},  32'(bus.a_rvalid),  32'd0);
        check({tag, ".b_rvalid"},  32'(bus.b_rvalid),  32'd0);
        check({tag, ".a_gnt"},     32'(bus.a_gnt),     32'd0);
        check({tag, ".b_gnt"},     32'(bus.b_gnt),     32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        @(posedge clk); #1;
        do_reset();
        check_quiet("reset");

        // Single read from preloaded address
        drive_a(1'b1, 1'b0, 1'b0, 16'h0010, 8'h00);
        cycle(1'b1, 1'b0, "rd_single");
        idle();
        check("rd.mem_read",  32'(bus.mem_read),  32'd1);
        check("rd.mem_write", 32'(bus.mem_write), 32'd0);
        check("rd.mem_addr",  32'(bus.mem_addr),  32'h0010);
        cycle(1'b0, 1'b0, "rd_idle");
        check("rd.mem_read_drop", 32'(bus.mem_read), 32'd0);
        repeat (3) cycle(1'b0, 1'b0, "rd_drain");

        // Continuous conflict without lock: strict alternation starting with A
        do_reset();
        ga_cnt = 0; gb_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            drive_a(1'b1, 1'b0, 1'b0, 16'h0040 + 16'(i), 8'h00);
            drive_b(1'b1, 1'b0, 1'b0, 16'h0080 + 16'(i), 8'h00);
            cycle((i % 2) == 0, (i % 2) == 1, "conflict");
        end
        idle();
        check("conflict.a_count", 32'(ga_cnt), 32'd4);
        check("conflict.b_count", 32'(gb_cnt), 32'd4);
        repeat (3) cycle(1'b0, 1'b0, "conflict_drain");

        // Write then read same address back-to-back
        drive_b(1'b1, 1'b1, 1'b0, 16'h1234, 8'hC3);
        cycle(1'b0, 1'b1, "wr_b");
        drive_b(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
        drive_a(1'b1, 1'b0, 1'b0, 16'h1234, 8'h00);
        check("wr.mem_write", 32'(bus.mem_write), 32'd1);
        check("wr.mem_read",  32'(bus.mem_read),  32'd0);
        check("wr.mem_addr",  32'(bus.mem_addr),  32'h1234);
        check("wr.mem_wdata", 32'(bus.mem_wdata), 32'hC3);
        cycle(1'b1, 1'b0, "rd_after_wr");
        idle();
        check("shadow_c3", 32'(shadow[8'h34]), 32'hC3);
        repeat (3) cycle(1'b0, 1'b0, "wr_drain");

        // Lock bound: A held 4 grants, B forced in on the 5th, then A relocks
        do_reset();
        for (int i = 0; i < 12; i++) begin
            drive_a(1'b1, 1'b0, 1'b1, 16'h0100 + 16'(i), 8'h00);
            drive_b(1'b1, 1'b0, 1'b0, 16'h0200 + 16'(i), 8'h00);
            cycle((i % 5) != 4, (i % 5) == 4, "lock_bound");
        end
        idle();
        repeat (3) cycle(1'b0, 1'b0, "lock_drain");

        // Lock without contention saturates; a late B request then wins at once
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive_a(1'b1, 1'b0, 1'b1, 16'h0300 + 16'(i), 8'h00);
            cycle(1'b1, 1'b0, "lock_solo");
        end
        drive_b(1'b1, 1'b0, 1'b0, 16'h0377, 8'h00);
        cycle(1'b0, 1'b1, "lock_sat_yield");
        idle();
        repeat (3) cycle(1'b0, 1'b0, "solo_drain");

        // Reset right after a read grant: no rvalid, outputs cleared, A wins first conflict
        drive_a(1'b1, 1'b0, 1'b0, 16'h0010, 8'h00);
        cycle(1'b1, 1'b0, "rst_rd");
        do_reset();
        check_quiet("post_reset");
        drive_a(1'b1, 1'b0, 1'b0, 16'h0011, 8'h00);
        drive_b(1'b1, 1'b0, 1'b0, 16'h0022, 8'h00);
        cycle(1'b1, 1'b0, "post_rst_conflict");
        cycle(1'b0, 1'b1, "post_rst_conflict");
        idle();
        repeat (4) cycle(1'b0, 1'b0, "final_drain");

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter that shares the single-port byte-wide memory between requester A (CPU) and requester B (DMA/video fetch).
- Accepts at most one access per cycle and registers the command into the memory's read/write/addr/write_byte inputs.
- Routes the returned read byte to the owning port with a valid strobe.
- Round-robin on conflict; optional bounded lock for bursts.

Parameters:
- ADDR_W, 16, address width (matches memory addr).
- DATA_W, 8, data width (matches memory bytes).
- MAX_LOCK, 8, max consecutive locked grants before forced yield to a waiting port; range 1..255.

Ports:
- clk  in  1  system clock, all logic on posedge.
- reset  in  1  synchronous, active-high.
- a_req  in  1  port A access request.
- a_we  in  1  port A: 1=write, 0=read.
- a_lock  in  1  port A requests to keep ownership next cycle.
- a_addr  in  ADDR_W  port A address.
- a_wdata  in  DATA_W  port A write data.
- a_gnt  out  1  combinational: A's request accepted this cycle.
- a_rdata  out  DATA_W  read data for A (valid only with a_rvalid).
- a_rvalid  out  1  one-cycle pulse, A's read data valid.
- b_*  same set as a_* for port B.
- mem_read  out  1  to memory read.
- mem_write  out  1  to memory write.
- mem_addr  out  ADDR_W  to memory addr.
- mem_wdata  out  DATA_W  to memory write_byte.
- mem_rdata  in  DATA_W  from memory read_byte.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port name reset.
- Reset values: mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, a_rvalid=b_rvalid=0, last_gnt=B (A wins first conflict), owner=NONE, lock_cnt=0.
- Grant (combinational, cycle N):
  - Only one requesting: it wins.
  - Both requesting, no active lock: port != last_gnt wins.
  - Active lock held by X: X wins while X_req && X_lock; the other port's gnt=0.
  - No req: no gnt.
  - a_gnt && b_gnt never both 1.
- Command register (posedge ending N):
  - Winner's addr/wdata go to mem_addr/mem_wdata.
  - mem_read = winner && !we; mem_write = winner && we.
  - No winner: mem_read=mem_write=0; addr/wdata hold.
  - last_gnt updates to the winner.
- Memory samples the command at posedge ending N+1. Read data reaches mem_rdata in N+2.
- Read return: 2-stage tag pipeline (valid + port id). X_rvalid=1 in cycle N+2 only, with X_rdata=mem_rdata (both ports' rdata may mirror mem_rdata; only rvalid qualifies). Writes produce no rvalid.
- Throughput: one access per cycle; back-to-back grants allowed. Reads and writes interleave freely.
- Lock/owner FSM (IDLE, LOCK_A, LOCK_B):
  - IDLE->LOCK_X when X granted with X_lock=1; lock_cnt=1.
  - In LOCK_X, each further grant to X increments lock_cnt.
  - Leave to IDLE when X drops req or lock.
  - Leave to IDLE when lock_cnt==MAX_LOCK and the other port requests. That cycle the other port wins, regardless of last_gnt.
  - lock_cnt saturates at MAX_LOCK if the other port is idle; X keeps winning.
- Write-then-read same address back-to-back: memory order is preserved; the read returns the new byte.
- Reset mid-operation: in-flight tags cleared, so no rvalid fires for commands issued before reset. mem_read/mem_write drop the cycle after reset.

Optional Feature:
- Macro MEM_ARB_TRACE_EN.
- Defined: on every grant, $display with $time, port (A/B), R/W, addr, and wdata (writes). On each rvalid, $display with port and data. Also a simulation check that errors ($display "mem_arbiter: double grant" + $finish) if both gnts are ever 1.
- Undefined: no display or check code compiled; logic identical.

Test Plan:
- Single read: after reset, A reads 0x0010 (preloaded 0x5A); a_req one cycle -> a_gnt=1 same cycle, mem_read=1 next cycle, a_rvalid=1 with a_rdata=0x5A exactly 2 cycles after grant; b_rvalid stays 0.
- Conflict: A and B both request reads continuously, no lock -> grants alternate A,B,A,B starting with A; 8 cycles give 4 each; rvalids alternate with matching data.
- Write/read ordering: B writes 0xC3 to 0x1234, next cycle A reads 0x1234 -> a_rdata=0xC3.
- Lock bound: MAX_LOCK=4, A req+lock continuously, B req continuously -> A granted 4 consecutive cycles, B granted cycle 5, then A relocks.
- Lock without contention: A locked 10 cycles, B idle -> A granted all 10; lock_cnt saturates at 4; no stalls.
- Reset mid-read: A read granted, reset asserted next cycle -> no a_rvalid pulse; all outputs 0 the cycle after reset; first post-reset conflict grants A.
